// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse stream decoder.
//   morse_state_t : receiver FSM states
//   CODE_*        : 6-bit letter codes, A-Z = 0..25, '0'-'9' = 26..35
//   CODE_INVALID  : reported for unknown patterns and over-long letters
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        LGAP  = 2'd3
    } morse_state_t;

    localparam logic [5:0] CODE_INVALID = 6'd63;

    localparam logic [5:0] CODE_A = 6'd0,  CODE_B = 6'd1,  CODE_C = 6'd2,  CODE_D = 6'd3;
    localparam logic [5:0] CODE_E = 6'd4,  CODE_F = 6'd5,  CODE_G = 6'd6,  CODE_H = 6'd7;
    localparam logic [5:0] CODE_I = 6'd8,  CODE_J = 6'd9,  CODE_K = 6'd10, CODE_L = 6'd11;
    localparam logic [5:0] CODE_M = 6'd12, CODE_N = 6'd13, CODE_O = 6'd14, CODE_P = 6'd15;
    localparam logic [5:0] CODE_Q = 6'd16, CODE_R = 6'd17, CODE_S = 6'd18, CODE_T = 6'd19;
    localparam logic [5:0] CODE_U = 6'd20, CODE_V = 6'd21, CODE_W = 6'd22, CODE_X = 6'd23;
    localparam logic [5:0] CODE_Y = 6'd24, CODE_Z = 6'd25;
    localparam logic [5:0] CODE_0 = 6'd26, CODE_1 = 6'd27, CODE_2 = 6'd28, CODE_3 = 6'd29;
    localparam logic [5:0] CODE_4 = 6'd30, CODE_5 = 6'd31, CODE_6 = 6'd32, CODE_7 = 6'd33;
    localparam logic [5:0] CODE_8 = 6'd34, CODE_9 = 6'd35;

endpackage

// File: rtl/morse_rom.sv
// Combinational Morse lookup: symbol count + pattern -> letter code.
//   len  in  3  number of symbols in the letter (1..5 are decodable)
//   pat  in  6  symbols, dot = 0 / dash = 1, first symbol is bit len-1
//   code out 6  letter code, CODE_INVALID for anything not in the table
// The upper pattern bits are matched as zero, so a stray bit above len
// decodes as invalid rather than aliasing onto a real letter.
module morse_rom
    import morse_pkg::*;
(
    input  logic [2:0] len,
    input  logic [5:0] pat,
    output logic [5:0] code
);

    always_comb begin
        code = CODE_INVALID;
        case ({len, pat})
            {3'd1, 6'b000000}: code = CODE_E;
            {3'd1, 6'b000001}: code = CODE_T;
            {3'd2, 6'b000000}: code = CODE_I;
            {3'd2, 6'b000001}: code = CODE_A;
            {3'd2, 6'b000010}: code = CODE_N;
            {3'd2, 6'b000011}: code = CODE_M;
            {3'd3, 6'b000000}: code = CODE_S;
            {3'd3, 6'b000001}: code = CODE_U;
            {3'd3, 6'b000010}: code = CODE_R;
            {3'd3, 6'b000011}: code = CODE_W;
            {3'd3, 6'b000100}: code = CODE_D;
            {3'd3, 6'b000101}: code = CODE_K;
            {3'd3, 6'b000110}: code = CODE_G;
            {3'd3, 6'b000111}: code = CODE_O;
            {3'd4, 6'b000000}: code = CODE_H;
            {3'd4, 6'b000001}: code = CODE_V;
            {3'd4, 6'b000010}: code = CODE_F;
            {3'd4, 6'b000100}: code = CODE_L;
            {3'd4, 6'b000110}: code = CODE_P;
            {3'd4, 6'b000111}: code = CODE_J;
            {3'd4, 6'b001000}: code = CODE_B;
            {3'd4, 6'b001001}: code = CODE_X;
            {3'd4, 6'b001010}: code = CODE_C;
            {3'd4, 6'b001011}: code = CODE_Y;
            {3'd4, 6'b001100}: code = CODE_Z;
            {3'd4, 6'b001101}: code = CODE_Q;
            {3'd5, 6'b011111}: code = CODE_0;
            {3'd5, 6'b001111}: code = CODE_1;
            {3'd5, 6'b000111}: code = CODE_2;
            {3'd5, 6'b000011}: code = CODE_3;
            {3'd5, 6'b000001}: code = CODE_4;
            {3'd5, 6'b000000}: code = CODE_5;
            {3'd5, 6'b010000}: code = CODE_6;
            {3'd5, 6'b011000}: code = CODE_7;
            {3'd5, 6'b011100}: code = CODE_8;
            {3'd5, 6'b011110}: code = CODE_9;
            default:           code = CODE_INVALID;
        endcase
    end

endmodule

// File: rtl/morse_stream_decoder.sv
// Morse receiver: classifies key presses as dot/dash, assembles letters,
// decodes them and flags letter gaps, word gaps and bad letters.
//   C      in   clock
//   aRn    in   asynchronous active-low reset
//   K      in   debounced key level, 1 = key down
//   CodeY  out  last decoded letter code (63 = invalid), held between letters
//   ValidY out  one-cycle pulse when CodeY is updated
//   ErrY   out  one-cycle pulse alongside ValidY when CodeY = 63
//   WordY  out  one-cycle pulse at end of a word
//   LenY   out  symbols buffered in the current letter
//   LedY   out  11 dash reached, 10 short mark, 01 letter space, 00 idle
//
// state | meaning
// IDLE  | no letter in progress, waiting for a key press
// MARK  | key down, mark counter running
// SPACE | key up inside a letter, waiting for the letter gap
// LGAP  | letter emitted, waiting for the word gap or the next press
module morse_stream_decoder
    import morse_pkg::*;
#(
    parameter int DIV      = 12_500_000,
    parameter int DASH_T   = 4,
    parameter int LETTER_T = 7,
    parameter int WORD_T   = 14,
    parameter int MAXSYM   = 5
) (
    input  logic       C,
    input  logic       aRn,
    input  logic       K,
    output logic [5:0] CodeY,
    output logic       ValidY,
    output logic       ErrY,
    output logic       WordY,
    output logic [2:0] LenY,
    output logic [1:0] LedY
);

    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = $clog2(WORD_T + 1);

    localparam logic [TW-1:0] TICK_LAST  = TW'(DIV - 1);
    localparam logic [CW-1:0] DASH_C     = CW'(DASH_T);
    localparam logic [CW-1:0] WORD_C     = CW'(WORD_T);
    localparam logic [CW-1:0] LETTER_PRE = CW'(LETTER_T - 1);
    localparam logic [CW-1:0] WORD_PRE   = CW'(WORD_T - 1);
    localparam logic [2:0]    MAX_LEN    = 3'(MAXSYM);

    logic [TW-1:0]     tcnt;
    logic              tick;
    logic              kq, rise, fall;
    logic [CW-1:0]     mark, space;
    logic [MAXSYM-1:0] pat;
    logic [2:0]        len;
    logic              ovf;
    logic              sym, letter_hit, word_hit;
    logic              emit, word_end;
    logic [5:0]        rom_pat, rom_code, code_nxt;
    morse_state_t      state, state_nxt;

    assign tick = (tcnt == TICK_LAST);
    assign rise = K & ~kq;
    assign fall = ~K & kq;
    assign sym  = (mark >= DASH_C);

    // Both gap events require K=0, so a rise in the same cycle always wins.
    assign letter_hit = tick & ~K & (space == LETTER_PRE);
    assign word_hit   = tick & ~K & (space == WORD_PRE);

    always_ff @(posedge C or negedge aRn) begin
        if (!aRn) begin
            tcnt <= '0;
            kq   <= 1'b0;
        end else begin
            tcnt <= tick ? '0 : tcnt + 1'b1;
            kq   <= K;
        end
    end

    // Space is also cleared on rise so an interrupted letter gap restarts
    // from zero; it cannot count while the key is down anyway.
    always_ff @(posedge C or negedge aRn) begin
        if (!aRn) begin
            mark  <= '0;
            space <= '0;
        end else begin
            if (rise)
                mark <= '0;
            else if (tick && K && mark < DASH_C)
                mark <= mark + 1'b1;

            if (fall || rise)
                space <= '0;
            else if (tick && !K && space < WORD_C)
                space <= space + 1'b1;
        end
    end

    always_ff @(posedge C or negedge aRn) begin
        if (!aRn) begin
            pat <= '0;
            len <= '0;
            ovf <= 1'b0;
        end else if (emit) begin
            pat <= '0;
            len <= '0;
            ovf <= 1'b0;
        end else if (fall) begin
            if (len < MAX_LEN) begin
                pat <= {pat[MAXSYM-2:0], sym};
                len <= len + 1'b1;
            end else begin
                ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge C or negedge aRn) begin
        if (!aRn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        word_end  = 1'b0;
        case (state)
            IDLE:  if (rise) state_nxt = MARK;
            MARK:  if (fall) state_nxt = SPACE;
            SPACE: begin
                if (rise) begin
                    state_nxt = MARK;
                end else if (letter_hit) begin
                    state_nxt = LGAP;
                    emit      = 1'b1;
                end
            end
            LGAP: begin
                if (rise) begin
                    state_nxt = MARK;
                end else if (word_hit) begin
                    state_nxt = IDLE;
                    word_end  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rom_pat = 6'(pat);

    morse_rom u_rom (
        .len  (len),
        .pat  (rom_pat),
        .code (rom_code)
    );

    assign code_nxt = ovf ? CODE_INVALID : rom_code;

    always_ff @(posedge C or negedge aRn) begin
        if (!aRn) begin
            CodeY  <= '0;
            ValidY <= 1'b0;
            ErrY   <= 1'b0;
            WordY  <= 1'b0;
        end else begin
            if (emit)
                CodeY <= code_nxt;
            ValidY <= emit;
            ErrY   <= emit && (code_nxt == CODE_INVALID);
            WordY  <= word_end;
        end
    end

    assign LenY = len;

    // Gated by state so a key still held through reset shows idle until
    // the press is re-detected.
    always_comb begin
        LedY = 2'b00;
        if (K && state != IDLE)
            LedY = (mark == DASH_C) ? 2'b11 : 2'b10;
        else if (!K && state == SPACE)
            LedY = 2'b01;
    end

endmodule

// File: tb/tb_morse_stream_decoder.sv
// Directed bench for morse_stream_decoder with DIV=4 (one tick = 4 clocks).
// Inputs change 1 time unit after a rising edge that follows a tick, so
// every key level lasts a whole number of ticks unless stated otherwise.
module tb_morse_stream_decoder;

    logic       C = 1'b0;
    logic       aRn = 1'b0;
    logic       K = 1'b0;
    logic [5:0] CodeY;
    logic       ValidY, ErrY, WordY;
    logic [2:0] LenY;
    logic [1:0] LedY;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc, n_valid, n_err, n_err_alone, n_word, valid_at, word_at;
    logic [5:0] last_code;

    morse_stream_decoder #(
        .DIV(4), .DASH_T(4), .LETTER_T(7), .WORD_T(14), .MAXSYM(5)
    ) dut (
        .C(C), .aRn(aRn), .K(K),
        .CodeY(CodeY), .ValidY(ValidY), .ErrY(ErrY), .WordY(WordY),
        .LenY(LenY), .LedY(LedY)
    );

    always #5 C = ~C;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        cyc = 0; n_valid = 0; n_err = 0; n_err_alone = 0; n_word = 0;
        valid_at = -1; word_at = -1; last_code = 6'd0;
    endtask

    task automatic drive(input logic k, input int n);
        K = k;
        for (int i = 0; i < n; i++) begin
            @(posedge C); #1;
            cyc++;
            if (ValidY === 1'b1) begin
                n_valid++;
                last_code = CodeY;
                valid_at = cyc;
                if (ErrY === 1'b1) n_err++;
            end else if (ErrY === 1'b1) begin
                n_err_alone++;
            end
            if (WordY === 1'b1) begin
                n_word++;
                word_at = cyc;
            end
        end
    endtask

    // one symbol of mark_ticks followed by a 1-tick intra-letter space
    task automatic send_sym(input int mark_ticks);
        drive(1'b1, 4 * mark_ticks);
        drive(1'b0, 4);
    endtask

    initial begin
        clr();
        repeat (3) @(posedge C);
        #1;
        check("rst_code",  CodeY,  0);
        check("rst_valid", ValidY, 0);
        check("rst_err",   ErrY,   0);
        check("rst_word",  WordY,  0);
        check("rst_len",   LenY,   0);
        check("rst_led",   LedY,   0);
        aRn = 1'b1;

        // "E": 1T mark, 8T space
        drive(1'b1, 4);
        check("e_led_mark", LedY, 2'b10);
        clr();
        drive(1'b0, 4);
        check("e_len1", LenY, 1);
        check("e_led_space", LedY, 2'b01);
        drive(1'b0, 28);
        check("e_valid", n_valid, 1);
        check("e_code", last_code, 4);
        check("e_latency", valid_at, 28);
        check("e_err", n_err, 0);
        check("e_len0", LenY, 0);
        check("e_noword", n_word, 0);
        check("e_led_lgap", LedY, 2'b00);

        // "A" then 15T space: one emit, one word pulse, none afterwards
        clr();
        send_sym(1);
        drive(1'b1, 16);
        check("a_led_dash", LedY, 2'b11);
        clr();
        drive(1'b0, 4);
        check("a_len2", LenY, 2);
        drive(1'b0, 56);
        check("a_valid", n_valid, 1);
        check("a_code", last_code, 0);
        check("a_valid_at", valid_at, 28);
        check("a_word", n_word, 1);
        check("a_word_at", word_at, 56);
        clr();
        drive(1'b0, 60);
        check("idle_noword", n_word, 0);
        check("idle_novalid", n_valid, 0);
        check("code_hold", CodeY, 0);

        // "0": five dashes
        clr();
        repeat (4) send_sym(4);
        drive(1'b1, 16);
        drive(1'b0, 4);
        check("zero_len5", LenY, 5);
        drive(1'b0, 28);
        check("zero_valid", n_valid, 1);
        check("zero_code", last_code, 26);
        check("zero_err", n_err, 0);

        // "..--.." overflows a 5-symbol buffer
        clr();
        send_sym(1); send_sym(1); send_sym(4); send_sym(4); send_sym(1);
        drive(1'b1, 4);
        drive(1'b0, 4);
        check("ovf_len_sat", LenY, 5);
        drive(1'b0, 28);
        check("ovf_valid", n_valid, 1);
        check("ovf_code", last_code, 63);
        check("ovf_err", n_err, 1);
        check("ovf_err_alone", n_err_alone, 0);

        // dash threshold: 3T is a dot (E), 4T is a dash (T)
        clr();
        drive(1'b1, 12);
        drive(1'b0, 32);
        check("mark3_code", last_code, 4);
        clr();
        drive(1'b1, 16);
        drive(1'b0, 32);
        check("mark4_code", last_code, 19);

        // press lands on the LETTER_T tick: no emit, letter continues as "A"
        clr();
        drive(1'b1, 4);
        drive(1'b0, 27);
        drive(1'b1, 1);
        check("race_novalid", n_valid, 0);
        check("race_len", LenY, 1);
        check("race_led", LedY, 2'b10);
        drive(1'b1, 16);
        drive(1'b0, 4);
        check("race_len2", LenY, 2);
        drive(1'b0, 28);
        check("race_valid", n_valid, 1);
        check("race_code", last_code, 0);

        // "..--": legal length, unassigned pattern
        clr();
        send_sym(1); send_sym(1); send_sym(4); send_sym(4);
        check("unk_len4", LenY, 4);
        drive(1'b0, 28);
        check("unk_valid", n_valid, 1);
        check("unk_code", last_code, 63);
        check("unk_err", n_err, 1);
        check("unk_err_alone", n_err_alone, 0);

        // reset while mark = 3 with one dot already buffered
        send_sym(1);
        drive(1'b0, 4);
        check("pre_len", LenY, 1);
        drive(1'b1, 12);
        check("pre_led", LedY, 2'b10);
        aRn = 1'b0;
        #1;
        check("mid_code",  CodeY,  0);
        check("mid_valid", ValidY, 0);
        check("mid_err",   ErrY,   0);
        check("mid_word",  WordY,  0);
        check("mid_len",   LenY,   0);
        check("mid_led",   LedY,   0);
        @(posedge C); #1;
        aRn = 1'b1;
        clr();
        drive(1'b1, 8);
        drive(1'b0, 32);
        check("post_rst_valid", n_valid, 1);
        check("post_rst_code", last_code, 4);
        check("post_rst_len", LenY, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
